// File: rtl/sorted_ram_pkg.sv
// Shared constants and insert-FSM state type for the sorted RAM writer/reader pair.
package sorted_ram_pkg;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CMP,
        WRVAL,
        DONE
    } ins_state_t;
endpackage

// File: rtl/sorted_insert_writer_if.sv
// Request/status and external read-port bundle of the sorted insert writer.
interface sorted_insert_writer_if;
    import sorted_ram_pkg::*;

    logic              start;
    logic [DATA_W-1:0] valueIn;
    logic              clear;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdData;
    logic              busy;
    logic              done;
    logic              rejected;
    logic [ADDR_W-1:0] insAddr;
    logic [ADDR_W:0]   count;
    logic              full;

    modport master (
        output start, valueIn, clear, rdAddr,
        input  rdData, busy, done, rejected, insAddr, count, full
    );

    modport slave (
        input  start, valueIn, clear, rdAddr,
        output rdData, busy, done, rejected, insAddr, count, full
    );
endinterface

// File: rtl/sorted_ram_mem.sv
// DEPTH x DATA_W simple dual-port RAM, synchronous write, registered read.
module sorted_ram_mem
    import sorted_ram_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        rd <= mem[ra];
    end
endmodule

// File: rtl/sorted_insert_writer.sv
// Inserts values into an ascending-sorted RAM, shifting larger entries up one slot.
module sorted_insert_writer
    import sorted_ram_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    sorted_insert_writer_if.slave  bus
);
    localparam logic [ADDR_W:0] COUNT_FULL = DEPTH[ADDR_W:0];

    ins_state_t        state, state_nxt;
    logic [DATA_W-1:0] val;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ins_addr_q;
    logic [ADDR_W:0]   count_q;
    logic              rejected_q;

    logic              full_w;
    logic              q_gt;
    logic              busy_w, done_w;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa, mem_ra;
    logic [DATA_W-1:0] mem_wd, mem_rd;

    assign full_w = (count_q == COUNT_FULL);
    // Strict compare keeps equal values below the new one, so equals stay in arrival order.
    assign q_gt   = (mem_rd > val);

    sorted_ram_mem u_mem (
        .clk (clk),
        .we  (mem_we),
        .wa  (mem_wa),
        .wd  (mem_wd),
        .ra  (mem_ra),
        .rd  (mem_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.clear && bus.start) begin
                    if (full_w)             state_nxt = DONE;
                    else if (count_q == '0) state_nxt = WRVAL;
                    else                    state_nxt = READ;
                end
            end
            READ:    state_nxt = CMP;
            CMP:     state_nxt = (q_gt && ptr != '0) ? READ : WRVAL;
            WRVAL:   state_nxt = DONE;
            DONE:    if (!bus.start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_w = (state == READ) || (state == CMP) || (state == WRVAL);
        done_w = (state == DONE);
        mem_ra = (state == IDLE) ? bus.rdAddr : ptr;
        mem_we = 1'b0;
        mem_wa = ins_addr_q;
        mem_wd = val;
        if (state == CMP && q_gt) begin
            mem_we = 1'b1;
            mem_wa = ptr + ADDR_W'(1);
            mem_wd = mem_rd;
        end else if (state == WRVAL) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            rejected_q <= 1'b0;
            ins_addr_q <= '0;
            val        <= '0;
            ptr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        count_q <= '0;
                    end else if (bus.start) begin
                        if (full_w) begin
                            rejected_q <= 1'b1;
                        end else begin
                            val <= bus.valueIn;
                            if (count_q == '0) ins_addr_q <= '0;
                            else               ptr <= count_q[ADDR_W-1:0] - ADDR_W'(1);
                        end
                    end
                end
                CMP: begin
                    if (q_gt) begin
                        if (ptr == '0) ins_addr_q <= '0;
                        else           ptr <= ptr - ADDR_W'(1);
                    end else begin
                        ins_addr_q <= ptr + ADDR_W'(1);
                    end
                end
                WRVAL: count_q <= count_q + (ADDR_W+1)'(1);
                DONE:  if (!bus.start) rejected_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.rdData   = mem_rd;
    assign bus.busy     = busy_w;
    assign bus.done     = done_w;
    assign bus.rejected = rejected_q;
    assign bus.insAddr  = ins_addr_q;
    assign bus.count    = count_q;
    assign bus.full     = full_w;
endmodule

// File: tb/tb_sorted_insert_writer.sv
// Directed + random insert sequence checked against a sorted-queue reference model.
module tb_sorted_insert_writer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [7:0] model[$];

    sorted_insert_writer_if bus_if ();

    sorted_insert_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input logic [4:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus_if.rdAddr = a;
        @(posedge clk);
        #1;
        check($sformatf("rd[%0d]", a), {24'h0, bus_if.rdData}, {24'h0, exp});
    endtask

    task automatic idle_clear();
        @(negedge clk);
        bus_if.clear = 1'b1;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.clear = 1'b0;
        bus_if.start = 1'b0;
        model.delete();
        check("clr_count", {26'h0, bus_if.count}, 32'd0);
        check("clr_busy",  {31'h0, bus_if.busy}, 32'd0);
        check("clr_done",  {31'h0, bus_if.done}, 32'd0);
    endtask

    // Expected placement/latency derived from the sorted-list view of the store.
    task automatic do_insert(input logic [7:0] v, input bit clr_mid);
        int n, idx, e, lat, cyc;
        bit is_full;
        n = model.size();
        is_full = (n == 32);
        idx = n;
        for (int i = 0; i < n; i++) begin
            if (model[i] > v) begin
                idx = i;
                break;
            end
        end
        if (is_full)       lat = 1;
        else if (n == 0)   lat = 2;
        else begin
            e   = (idx == 0) ? n : (n - idx + 1);
            lat = 2 * e + 2;
        end

        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.valueIn = v;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                bus_if.valueIn = 8'($urandom);
                if (!is_full) check("busy_mid", {31'h0, bus_if.busy}, 32'd1);
            end
            if (clr_mid && cyc == 2) bus_if.clear = 1'b1;
        end while (!bus_if.done && cyc < 200);
        bus_if.clear = 1'b0;

        check("done",     {31'h0, bus_if.done}, 32'd1);
        check("latency",  cyc, lat);
        check("rejected", {31'h0, bus_if.rejected}, {31'h0, is_full});
        if (!is_full) begin
            check("insAddr", {27'h0, bus_if.insAddr}, idx);
            model.insert(idx, v);
        end
        check("count", {26'h0, bus_if.count}, model.size());
        check("full",  {31'h0, bus_if.full}, {31'h0, (model.size() == 32)});

        @(posedge clk);
        #1;
        check("done_hold", {31'h0, bus_if.done}, 32'd1);
        @(negedge clk);
        bus_if.start = 1'b0;
        @(posedge clk);
        #1;
        check("done_drop", {31'h0, bus_if.done}, 32'd0);
        check("rej_drop",  {31'h0, bus_if.rejected}, 32'd0);
        check("idle_busy", {31'h0, bus_if.busy}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset          = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.valueIn = '0;
        bus_if.clear   = 1'b0;
        bus_if.rdAddr  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    {31'h0, bus_if.busy}, 32'd0);
        check("rst_done",    {31'h0, bus_if.done}, 32'd0);
        check("rst_rej",     {31'h0, bus_if.rejected}, 32'd0);
        check("rst_insAddr", {27'h0, bus_if.insAddr}, 32'd0);
        check("rst_count",   {26'h0, bus_if.count}, 32'd0);
        check("rst_full",    {31'h0, bus_if.full}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Empty-store insert and read-back.
        do_insert(8'h40, 1'b0);
        read_chk(5'd0, 8'h40);
        idle_clear();

        // Appends, middle insert, head insert, duplicate.
        do_insert(8'h10, 1'b0);
        do_insert(8'h20, 1'b0);
        do_insert(8'h30, 1'b0);
        do_insert(8'h15, 1'b0);
        for (int i = 0; i < 4; i++) read_chk(5'(i), model[i]);
        do_insert(8'h05, 1'b0);
        do_insert(8'h15, 1'b0);
        for (int i = 0; i < model.size(); i++) read_chk(5'(i), model[i]);

        // Random fill to capacity, then a rejected request.
        while (model.size() < 32) do_insert(8'($urandom_range(0, 255)), 1'b0);
        do_insert(8'h00, 1'b0);
        for (int i = 0; i < 32; i++) read_chk(5'(i), model[i]);

        // Reset while shifting.
        idle_clear();
        for (int i = 0; i < 6; i++) do_insert(8'($urandom_range(32, 255)), 1'b0);
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.valueIn = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'h0, bus_if.busy}, 32'd1);
        @(negedge clk);
        reset        = 1'b1;
        bus_if.start = 1'b0;
        @(posedge clk);
        #1;
        model.delete();
        check("mid_rst_busy",  {31'h0, bus_if.busy}, 32'd0);
        check("mid_rst_count", {26'h0, bus_if.count}, 32'd0);
        check("mid_rst_done",  {31'h0, bus_if.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_insert(8'h77, 1'b0);

        // Clear while busy is ignored; clear in idle empties the store.
        for (int i = 0; i < 3; i++) do_insert(8'($urandom), 1'b0);
        do_insert(8'($urandom), 1'b1);
        check("count5", {26'h0, bus_if.count}, 32'd5);
        idle_clear();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
